// File: rtl/mips_imem_loader.sv
// Boot-time loader: assembles a little-endian byte stream into 32-bit words for the core's
// instruction memory and holds the core in reset until the image is written. Optional macro: CHECKSUM_EN.
module mips_imem_loader #(
   parameter int MEM_BYTES = 128,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   input  logic [7:0]        s_data,
   output logic              s_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int          CW    = ADDR_W - 1;
   localparam logic [7:0]  MAX_N = 8'(MEM_BYTES / 4);

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LEN = 3'd1, ST_DATA = 3'd2, ST_CHK = 3'd3, ST_DONE = 3'd4, ST_ERR = 3'd5
   } state_t;

   function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   logic [7:0]  chk_r;
`else
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0, ST_LEN = 3'd1, ST_DATA = 3'd2, ST_DONE = 3'd4, ST_ERR = 3'd5
   } state_t;
`endif

   state_t          state_r;
   logic [CW-1:0]   n_r;
   logic [CW-2:0]   word_idx_r;
   logic [1:0]      byte_idx_r;
   logic [23:0]     buf_r;
   logic            xfer_s;
   logic [CW-1:0]   word_nxt_s;
   logic            last_word_s;

   // transfer qualifier and end-of-image detection
   always_comb begin
      xfer_s      = s_valid && s_ready;
      word_nxt_s  = {1'b0, word_idx_r} + {{(CW-1){1'b0}}, 1'b1};
      last_word_s = (word_nxt_s == n_r);
   end

   // loader state machine with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         n_r        <= '0;
         word_idx_r <= '0;
         byte_idx_r <= 2'd0;
         buf_r      <= 24'd0;
`ifdef CHECKSUM_EN
         chk_r      <= 8'd0;
`endif
         s_ready    <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 32'd0;
         core_rst   <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         wr_en <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_r    <= ST_LEN;
                  word_idx_r <= '0;
                  byte_idx_r <= 2'd0;
`ifdef CHECKSUM_EN
                  chk_r      <= 8'd0;
`endif
                  done       <= 1'b0;
                  err        <= 1'b0;
                  core_rst   <= 1'b1;
                  s_ready    <= 1'b1;
                  busy       <= 1'b1;
               end else if (state_r == ST_DONE) begin
                  core_rst <= 1'b0;
               end else begin
                  core_rst <= 1'b1;
               end
            end
            ST_LEN: begin
               if (xfer_s) begin
                  n_r <= s_data[CW-1:0];
                  if (s_data > MAX_N) begin
                     state_r <= ST_ERR;
                     err     <= 1'b1;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
                  end else if (s_data == 8'd0) begin
`ifdef CHECKSUM_EN
                     state_r <= ST_CHK;
`else
                     state_r <= ST_DONE;
                     done    <= 1'b1;
                     s_ready <= 1'b0;
                     busy    <= 1'b0;
`endif
                  end else begin
                     state_r <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer_s) begin
                  byte_idx_r <= byte_idx_r + 2'd1;
`ifdef CHECKSUM_EN
                  chk_r      <= chk_fold(chk_r, s_data);
`endif
                  case (byte_idx_r)
                     2'd0: buf_r[7:0]   <= s_data;
                     2'd1: buf_r[15:8]  <= s_data;
                     2'd2: buf_r[23:16] <= s_data;
                     2'd3: begin
                        wr_en      <= 1'b1;
                        wr_addr    <= {word_idx_r, 2'b00};
                        wr_data    <= {s_data, buf_r};
                        word_idx_r <= word_nxt_s[CW-2:0];
                        if (last_word_s) begin
`ifdef CHECKSUM_EN
                           state_r <= ST_CHK;
`else
                           state_r <= ST_DONE;
                           done    <= 1'b1;
                           s_ready <= 1'b0;
                           busy    <= 1'b0;
`endif
                        end
                     end
                     default: buf_r <= buf_r;
                  endcase
               end
            end
`ifdef CHECKSUM_EN
            // trailer byte: match releases the core, mismatch keeps it in reset
            ST_CHK: begin
               if (xfer_s) begin
                  s_ready <= 1'b0;
                  busy    <= 1'b0;
                  if (s_data == chk_r) begin
                     state_r <= ST_DONE;
                     done    <= 1'b1;
                  end else begin
                     state_r <= ST_ERR;
                     err     <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_r  <= ST_IDLE;
               s_ready  <= 1'b0;
               busy     <= 1'b0;
               core_rst <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips_imem_loader.sv
// Directed bench for mips_imem_loader; follows the CHECKSUM_EN define of the build.
module tb_mips_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        s_ready;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [31:0] wr_data;
   logic        core_rst;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_wr_cyc = -1;
   int fall_cyc = -1;
   logic prev_crst = 1'b1;
   logic [6:0]  aq[$];
   logic [31:0] dq[$];

   mips_imem_loader #(.MEM_BYTES(128), .ADDR_W(7)) dut (
      .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .core_rst(core_rst), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // write and core-release monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (wr_en) begin
         aq.push_back(wr_addr);
         dq.push_back(wr_data);
         last_wr_cyc = cyc;
      end
      if (prev_crst && !core_rst) fall_cyc = cyc;
      prev_crst = core_rst;
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, act, exp);
      end
   endtask

   task automatic expect_write(input int idx, input logic [6:0] a, input logic [31:0] d);
      if (idx < aq.size()) begin
         check_val("wr_addr", {25'd0, aq[idx]}, {25'd0, a});
         check_val("wr_data", dq[idx], d);
      end else begin
         check_val("wr_missing", aq.size(), idx + 1);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall_n);
      int n;
      repeat (stall_n) begin
         @(negedge clk);
         s_valid = 1'b0;
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("ready_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic send_image(input logic [7:0] img[$], input int max_stall);
      foreach (img[i]) send_byte(img[i], (max_stall > 0) ? $urandom_range(0, max_stall) : 0);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      s_valid = 1'b0;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic settle(input int n);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   logic [7:0] img[$];
   int base;

   initial begin
      // 1: reset
      repeat (3) @(negedge clk);
      check_val("rst_core_rst", core_rst, 1'b1);
      check_val("rst_s_ready", s_ready, 1'b0);
      check_val("rst_wr_en", wr_en, 1'b0);
      check_val("rst_done", done, 1'b0);
      check_val("rst_err", err, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      rst = 1'b1;

      // 2: two-word image, no stalls
      base = aq.size();
      img = {8'h02, 8'h13, 8'h00, 8'h08, 8'h20, 8'h00, 8'h00, 8'h00, 8'h08};
`ifdef CHECKSUM_EN
      img.push_back(8'h33);
`endif
      pulse_start();
      check_val("t2_busy", busy, 1'b1);
      send_image(img, 0);
`ifndef CHECKSUM_EN
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h55;
      repeat (3) @(negedge clk);
      check_val("t2_no_consume", s_ready, 1'b0);
`endif
      settle(3);
      check_val("t2_nwr", aq.size() - base, 2);
      expect_write(base, 7'd0, 32'h20080013);
      expect_write(base + 1, 7'd4, 32'h08000000);
      check_val("t2_done", done, 1'b1);
      check_val("t2_err", err, 1'b0);
      check_val("t2_core_rst", core_rst, 1'b0);
      check_val("t2_busy_end", busy, 1'b0);
`ifndef CHECKSUM_EN
      check_val("t2_rel_lat", fall_cyc - last_wr_cyc, 1);
`endif

      // 3: same image with random stalls
      base = aq.size();
      pulse_start();
      check_val("t3_core_rst_hold", core_rst, 1'b1);
      send_image(img, 5);
      settle(3);
      check_val("t3_nwr", aq.size() - base, 2);
      expect_write(base, 7'd0, 32'h20080013);
      expect_write(base + 1, 7'd4, 32'h08000000);
      check_val("t3_done", done, 1'b1);

      // 4: oversize N, then recovery
      base = aq.size();
      pulse_start();
      send_byte(8'h21, 0);
      settle(2);
      check_val("t4_err", err, 1'b1);
      check_val("t4_core_rst", core_rst, 1'b1);
      check_val("t4_s_ready", s_ready, 1'b0);
      check_val("t4_nwr", aq.size() - base, 0);
      img = {8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef CHECKSUM_EN
      img.push_back(8'h00);
`endif
      pulse_start();
      check_val("t4_err_clr", err, 1'b0);
      send_image(img, 0);
      settle(3);
      check_val("t4r_nwr", aq.size() - base, 1);
      expect_write(base, 7'd0, 32'hDDCCBBAA);
      check_val("t4r_err", err, 1'b0);
      check_val("t4r_done", done, 1'b1);

      // 4b: largest image, 32 words
      base = aq.size();
      img = {8'h20};
      for (int i = 0; i < 128; i++) img.push_back(8'(i));
`ifdef CHECKSUM_EN
      img.push_back(8'h00);
`endif
      pulse_start();
      send_image(img, 0);
      settle(3);
      check_val("tmax_nwr", aq.size() - base, 32);
      expect_write(base, 7'd0, 32'h03020100);
      expect_write(base + 31, 7'd124, 32'h7F7E7D7C);
      check_val("tmax_done", done, 1'b1);

`ifdef CHECKSUM_EN
      // 5: checksum match and mismatch
      base = aq.size();
      img = {8'h01, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFF};
      pulse_start();
      send_image(img, 0);
      settle(3);
      check_val("t5_done", done, 1'b1);
      check_val("t5_core_rst", core_rst, 1'b0);
      img = {8'h01, 8'h11, 8'h22, 8'h44, 8'h88, 8'hFE};
      pulse_start();
      send_image(img, 0);
      settle(3);
      check_val("t5b_err", err, 1'b1);
      check_val("t5b_core_rst", core_rst, 1'b1);
      check_val("t5b_nwr", aq.size() - base, 2);
      expect_write(base + 1, 7'd0, 32'h88442211);
`endif

      // 6: reset mid-load, then empty image
      base = aq.size();
      pulse_start();
      send_byte(8'h02, 0);
      @(negedge clk);
      s_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      img = {8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22};
      send_image(img, 0);
      @(negedge clk);
      check_val("t6_busy_mid", busy, 1'b1);
      s_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_val("t6_core_rst_async", core_rst, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      s_valid = 1'b1;
      s_data = 8'h33;
      repeat (3) @(negedge clk);
      check_val("t6_nwr", aq.size() - base, 1);
      expect_write(base, 7'd0, 32'h04030201);
      check_val("t6_s_ready", s_ready, 1'b0);
      check_val("t6_busy", busy, 1'b0);
      check_val("t6_core_rst", core_rst, 1'b1);
      img = {8'h00};
`ifdef CHECKSUM_EN
      img.push_back(8'h00);
`endif
      pulse_start();
      send_image(img, 0);
      settle(3);
      check_val("t6z_done", done, 1'b1);
      check_val("t6z_core_rst", core_rst, 1'b0);
      check_val("t6z_nwr", aq.size() - base, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
